// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding and
// default reset PC / sequential step.
package if_fetch_unit_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_SKID  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

  // Sequential fetch address; 32-bit modulo so it wraps silently past 0xFFFF_FFFC.
  function automatic logic [31:0] step_pc(input logic [31:0] pc, input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/if_fetch_unit_skid_reg.sv
// 64-bit {instruction, pc} holding register with clear > load > hold priority.
// Used both for the skid slot and for the decode-facing output register.
module fetch_skid_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [63:0] d,
  output logic [63:0] q
);

  // Register update: clear wins over load; otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 64'd0;
    end else if (clear) begin
      q <= 64'd0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end. Holds the fetch address, talks to a
// variable-latency instruction memory over req/ack, delivers {instruction, pc}
// to decode through a registered output, parks one instruction in a skid slot
// while decode is frozen, and redirects on a taken branch.
//
// Memory handshake: imem_req=1 presents imem_addr; the address is held stable
// until imem_ack=1 is sampled on a rising edge, at which point imem_rdata is
// captured. imem_ack is ignored while imem_req=0. A new address goes out the
// cycle after ack, so a zero-wait memory sustains one instruction per clock.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  fetch_state_e state;
  logic         drop;
  logic [31:0]  pc;
  logic [31:0]  req_addr;
  logic         valid_q;

  logic         ack_v;
  logic [31:0]  seq_addr;
  logic         skid_load;
  logic         skid_clear;
  logic         out_load;
  logic [63:0]  skid_d;
  logic [63:0]  skid_q;
  logic [63:0]  out_d;
  logic [63:0]  out_q;

  // Decode of the skid/output register controls from the current state and inputs.
  always_comb begin
    ack_v      = imem_req & imem_ack;
    seq_addr   = step_pc(req_addr, PC_STEP);
    skid_d     = {imem_rdata, seq_addr};
    skid_clear = br_taken;
    skid_load  = 1'b0;
    out_load   = 1'b0;
    out_d      = skid_d;
    if (!br_taken) begin
      if (state == ST_FETCH) begin
        if (ack_v && !drop) begin
          skid_load = freeze;
          out_load  = !freeze;
        end
      end else begin
        out_load = !freeze;
        out_d    = skid_q;
      end
    end
  end

  fetch_skid_reg u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (skid_d),
    .q     (skid_q)
  );

  fetch_skid_reg u_out (
    .clk   (clk),
    .rst   (rst),
    .load  (out_load),
    .clear (1'b0),
    .d     (out_d),
    .q     (out_q)
  );

  // Fetch FSM: branch redirect first, then memory handshake and freeze handling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FETCH;
      imem_req <= 1'b0;
      req_addr <= RESET_PC;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      valid_q  <= 1'b0;
    end else if (br_taken) begin
      // Redirect. If a request is still waiting for ack, its address must stay
      // on the bus, so remember the target and discard the data when it lands.
      valid_q  <= 1'b0;
      state    <= ST_FETCH;
      imem_req <= 1'b1;
      pc       <= br_target;
      if (!imem_req || imem_ack) begin
        req_addr <= br_target;
        drop     <= 1'b0;
      end else begin
        drop <= 1'b1;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          imem_req <= 1'b1;
          if (ack_v) begin
            if (drop) begin
              drop     <= 1'b0;
              req_addr <= pc;
              if (!freeze) valid_q <= 1'b0;
            end else if (!freeze) begin
              valid_q  <= 1'b1;
              req_addr <= seq_addr;
            end else begin
              // Decode is stalled: park the fetched word and stop requesting.
              req_addr <= seq_addr;
              state    <= ST_SKID;
              imem_req <= 1'b0;
            end
          end else if (!freeze) begin
            valid_q <= 1'b0;
          end
        end
        ST_SKID: begin
          if (!freeze) begin
            valid_q  <= 1'b1;
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= ST_FETCH;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = req_addr;
  assign instruction = out_q[63:32];
  assign pc_out      = out_q[31:0];
  assign valid_out   = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural memory with programmable latency,
// directed stimulus with hand-computed expected deliveries, and a monitor
// that pops the expected queue whenever decode consumes an instruction.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid_out;

  int lat;
  int wait_cnt;
  int vectors;
  int miscompares;
  logic [63:0] exp_q[$];

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_out      (pc_out),
    .valid_out   (valid_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign imem_ack   = imem_req && (wait_cnt >= lat - 1);
  assign imem_rdata = mem_word(imem_addr);

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    logic [31:0] fa;
    fa = pc - 32'd4;
    exp_q.push_back({mem_word(fa), pc});
  endtask

  task automatic reset_dut(input int l);
    rst       = 1'b0;
    freeze    = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'd0;
    lat       = l;
    @(posedge clk);
    #1;
    check("rst_req",   {63'd0, imem_req},  64'd0);
    check("rst_addr",  {32'd0, imem_addr}, 64'd0);
    check("rst_valid", {63'd0, valid_out}, 64'd0);
    check("rst_out",   {instruction, pc_out}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait (bounded) for every expected delivery, then stop the DUT via reset.
  task automatic end_test(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  // Decode consumes the presented instruction on any edge where it is valid
  // and decode is not frozen.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (rst && valid_out && !freeze) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL deliver_unexpected: got %h expected none", {instruction, pc_out});
        end else begin
          exp = exp_q.pop_front();
          check("deliver", {instruction, pc_out}, exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    freeze      = 1'b0;
    br_taken    = 1'b0;
    br_target   = 32'd0;
    lat         = 1;

    // 1: zero-wait streaming
    reset_dut(1);
    push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    step();
    check("t1_req1",  {63'd0, imem_req},  64'd1);
    check("t1_addr0", {32'd0, imem_addr}, 64'h0);
    check("t1_bub",   {63'd0, valid_out}, 64'd0);
    step();
    check("t1_addr4", {32'd0, imem_addr}, 64'h4);
    check("t1_v",     {63'd0, valid_out}, 64'd1);
    check("t1_pc",    {32'd0, pc_out},    64'h4);
    step();
    check("t1_addr8", {32'd0, imem_addr}, 64'h8);
    end_test("t1");

    // 2: freeze over the ack of address 8
    reset_dut(1);
    push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10); push_exp(32'h14);
    repeat (3) step();
    freeze = 1'b1;
    check("t2_pc8", {32'd0, pc_out}, 64'h8);
    step();
    check("t2_skid_req", {63'd0, imem_req}, 64'd0);
    check("t2_hold1", {instruction, pc_out}, {mem_word(32'h4), 32'h8});
    step();
    check("t2_skid_req2", {63'd0, imem_req}, 64'd0);
    check("t2_hold2", {instruction, pc_out}, {mem_word(32'h4), 32'h8});
    step();
    freeze = 1'b0;
    step();
    check("t2_rel", {instruction, pc_out}, {mem_word(32'h8), 32'hC});
    check("t2_rel_req", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'hC});
    end_test("t2");

    // 3: zero-wait branch while 0xC is being fetched
    reset_dut(1);
    push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h104); push_exp(32'h108);
    repeat (4) step();
    check("t3_addrC", {32'd0, imem_addr}, 64'hC);
    br_taken = 1'b1; br_target = 32'h100;
    step();
    br_taken = 1'b0;
    check("t3_bub", {63'd0, valid_out}, 64'd0);
    check("t3_redir", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h100});
    step();
    check("t3_tgt", {31'd0, valid_out, pc_out}, {31'd0, 1'b1, 32'h104});
    end_test("t3");

    // 4: 3-cycle memory, branch while waiting on 0x10
    reset_dut(3);
    push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10); push_exp(32'h204);
    repeat (13) step();
    br_taken = 1'b1; br_target = 32'h200;
    step();
    br_taken = 1'b0;
    check("t4_hold1", {31'd0, valid_out, imem_addr}, {31'd0, 1'b0, 32'h10});
    step();
    check("t4_hold2", {31'd0, valid_out, imem_addr}, {31'd0, 1'b0, 32'h10});
    step();
    check("t4_redir", {31'd0, valid_out, imem_addr}, {31'd0, 1'b0, 32'h200});
    repeat (3) step();
    check("t4_tgt", {31'd0, valid_out, pc_out}, {31'd0, 1'b1, 32'h204});
    end_test("t4");

    // 5: branch while an instruction sits in the skid slot
    reset_dut(1);
    push_exp(32'h4); push_exp(32'h8); push_exp(32'h304); push_exp(32'h308);
    repeat (3) step();
    freeze = 1'b1;
    step();
    check("t5_skid", {63'd0, imem_req}, 64'd0);
    freeze = 1'b0;
    br_taken = 1'b1; br_target = 32'h300;
    step();
    br_taken = 1'b0;
    check("t5_bub", {63'd0, valid_out}, 64'd0);
    check("t5_redir", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h300});
    step();
    check("t5_tgt", {instruction, pc_out}, {mem_word(32'h300), 32'h304});
    end_test("t5");

    // 6: asynchronous reset in the middle of a wait
    reset_dut(3);
    push_exp(32'h4);
    repeat (4) step();
    check("t6_v", {31'd0, valid_out, pc_out}, {31'd0, 1'b1, 32'h4});
    step();
    rst = 1'b0;
    #1;
    check("t6_async_req", {31'd0, imem_req, imem_addr}, 64'd0);
    check("t6_async_out", {instruction, pc_out}, 64'd0);
    check("t6_async_v", {63'd0, valid_out}, 64'd0);
    check("t6_q", {32'd0, exp_q.size()}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    push_exp(32'h4);
    step();
    check("t6_restart", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0});
    end_test("t6");

    // 7: PC wraps from 0xFFFF_FFFC to 0
    reset_dut(1);
    push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4);
    step();
    br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
    step();
    br_taken = 1'b0;
    check("t7_redir", {31'd0, valid_out, imem_addr}, {31'd0, 1'b0, 32'hFFFF_FFF8});
    repeat (2) step();
    check("t7_wrap", {31'd0, valid_out, pc_out}, {31'd0, 1'b1, 32'h0});
    check("t7_addr", {32'd0, imem_addr}, 64'h0);
    end_test("t7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
